// File: rtl/uart_fifo_ctrl_if.sv
// Purpose : Handshake, flag and memory-port bundle between the UART 16750 FIFO
//           controller and its user/memory side.
// Modports:
//   slave  - controller view: takes CLEAR/FIFO64/TRIG/PUSH/POP/OVR_CLR,
//            drives PUSH_RDY, DVALID, memory strobes/addresses and flags.
//   master - user view: the mirror image of slave.
interface uart_fifo_ctrl_if #(
    parameter int unsigned SIZE_E = 6
);
    logic              CLEAR;
    logic              FIFO64;
    logic [1:0]        TRIG;
    logic              PUSH;
    logic              PUSH_RDY;
    logic              POP;
    logic              DVALID;
    logic              MEM_READ;
    logic              MEM_WRITE;
    logic [SIZE_E:0]   MEM_RADDR;
    logic [SIZE_E:0]   MEM_WADDR;
    logic [SIZE_E:0]   COUNT;
    logic              EMPTY;
    logic              FULL;
    logic              TRIG_HIT;
    logic              OVERRUN;
    logic              OVR_CLR;

    modport slave (
        input  CLEAR, FIFO64, TRIG, PUSH, POP, OVR_CLR,
        output PUSH_RDY, DVALID, MEM_READ, MEM_WRITE, MEM_RADDR, MEM_WADDR,
               COUNT, EMPTY, FULL, TRIG_HIT, OVERRUN
    );

    modport master (
        output CLEAR, FIFO64, TRIG, PUSH, POP, OVR_CLR,
        input  PUSH_RDY, DVALID, MEM_READ, MEM_WRITE, MEM_RADDR, MEM_WADDR,
               COUNT, EMPTY, FULL, TRIG_HIT, OVERRUN
    );
endinterface

// File: rtl/uart_fifo_ctrl.sv
// Purpose : Pointer, flag and handshake controller for the UART 16750 RX/TX
//           FIFO storage array (2**SIZE_E entries, registered read).
// Ports   :
//   CLK  - clock, rising edge
//   RST  - asynchronous active-high reset
//   bus  - uart_fifo_ctrl_if.slave: push/pop handshake, memory strobes and
//          addresses, fill level and status flags.
module uart_fifo_ctrl #(
    parameter int unsigned      SIZE_E = 6,
    parameter logic [3:0][3:0]  TRIG16 = {4'd14, 4'd8, 4'd4, 4'd1},
    parameter logic [3:0][5:0]  TRIG64 = {6'd56, 6'd32, 6'd16, 6'd1}
) (
    input  logic              CLK,
    input  logic              RST,
    uart_fifo_ctrl_if.slave   bus
);

    typedef logic [SIZE_E:0] ptr_t;

    localparam ptr_t Cap64 = ptr_t'(1) << SIZE_E;
    localparam ptr_t Cap16 = ptr_t'(16);

    ptr_t r_rptr, r_rptr_d;
    ptr_t r_wptr, r_wptr_d;
    ptr_t r_count, r_count_d;
    logic r_dvalid, r_dvalid_d;
    logic r_overrun, r_overrun_d;
    logic r_fifo64;

    logic        w_empty;
    logic        w_full;
    ptr_t        w_cap;
    logic [7:0]  w_thresh;
    logic        w_trig_hit;
    logic        w_clear;
    logic        w_pop_ok;
    logic        w_push_rdy;
    logic        w_write;
    logic        w_ovr_set;

    // Flags come from registered COUNT only; PUSH/POP never reach them.
    assign w_empty    = (r_count == '0);
    assign w_cap      = bus.FIFO64 ? Cap64 : Cap16;
    assign w_full     = (r_count == w_cap);
    assign w_thresh   = bus.FIFO64 ? 8'(TRIG64[bus.TRIG]) : 8'(TRIG16[bus.TRIG]);
    assign w_trig_hit = (32'(r_count) >= 32'(w_thresh));

    // A mode switch flushes exactly like CLEAR.
    assign w_clear    = bus.CLEAR || (bus.FIFO64 != r_fifo64);

    // Memory gives read priority: a pop blocks a concurrent push.
    assign w_pop_ok   = bus.POP && !w_empty && !w_clear;
    assign w_push_rdy = !w_full && !w_pop_ok && !w_clear;
    assign w_write    = bus.PUSH && w_push_rdy;
    assign w_ovr_set  = bus.PUSH && w_full;

    always_comb begin
        r_rptr_d    = r_rptr;
        r_wptr_d    = r_wptr;
        r_count_d   = r_count;
        r_dvalid_d  = w_pop_ok;
        r_overrun_d = r_overrun;

        if (w_clear) begin
            r_rptr_d   = '0;
            r_wptr_d   = '0;
            r_count_d  = '0;
            r_dvalid_d = 1'b0;
        end else if (w_pop_ok) begin
            r_rptr_d  = r_rptr + ptr_t'(1);
            r_count_d = r_count - ptr_t'(1);
        end else if (w_write) begin
            r_wptr_d  = r_wptr + ptr_t'(1);
            r_count_d = r_count + ptr_t'(1);
        end

        // Set wins over a coincident clear request.
        if (w_ovr_set) begin
            r_overrun_d = 1'b1;
        end else if (bus.OVR_CLR) begin
            r_overrun_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_rptr    <= '0;
            r_wptr    <= '0;
            r_count   <= '0;
            r_dvalid  <= 1'b0;
            r_overrun <= 1'b0;
            r_fifo64  <= 1'b0;
        end else begin
            r_rptr    <= r_rptr_d;
            r_wptr    <= r_wptr_d;
            r_count   <= r_count_d;
            r_dvalid  <= r_dvalid_d;
            r_overrun <= r_overrun_d;
            r_fifo64  <= bus.FIFO64;
        end
    end

    // While RST is high every output is forced idle without waiting for an edge.
    assign bus.PUSH_RDY  = w_push_rdy && !RST;
    assign bus.MEM_READ  = w_pop_ok && !RST;
    assign bus.MEM_WRITE = w_write && !RST;
    assign bus.MEM_RADDR = r_rptr;
    assign bus.MEM_WADDR = r_wptr;
    assign bus.DVALID    = r_dvalid;
    assign bus.COUNT     = r_count;
    assign bus.EMPTY     = w_empty;
    assign bus.FULL      = w_full;
    assign bus.TRIG_HIT  = w_trig_hit;
    assign bus.OVERRUN   = r_overrun;

endmodule

// File: tb/tb_uart_fifo_ctrl.sv
// Purpose : Self-checking bench for uart_fifo_ctrl. Stimulus queues the
//           expected memory addresses; a negedge monitor pops and compares
//           whenever a strobe appears, and checks DVALID follows MEM_READ.
module tb_uart_fifo_ctrl;

    localparam int unsigned SIZE_E = 6;
    localparam int          PMASK  = (1 << (SIZE_E + 1)) - 1;

    logic CLK;
    logic RST;

    uart_fifo_ctrl_if #(.SIZE_E(SIZE_E)) bus ();

    uart_fifo_ctrl #(.SIZE_E(SIZE_E)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_pass = 0;
    int n_total = 0;

    int exp_waddr[$];
    int exp_raddr[$];
    int exp_wptr = 0;
    int exp_rptr = 0;
    logic exp_dv = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Scoreboard monitor: sampled mid-cycle, away from the active edge.
    always @(negedge CLK) begin
        if (RST) begin
            exp_dv = 1'b0;
        end else begin
            if (exp_dv || bus.DVALID) chk("dvalid_after_read", int'(bus.DVALID), int'(exp_dv));
            if (bus.MEM_READ && bus.MEM_WRITE) chk("read_write_exclusive", 1, 0);
            if (bus.MEM_WRITE) begin
                if (exp_waddr.size() == 0) chk("unexpected_write", 1, 0);
                else chk("mem_waddr", int'(bus.MEM_WADDR), exp_waddr.pop_front());
            end
            if (bus.MEM_READ) begin
                if (exp_raddr.size() == 0) chk("unexpected_read", 1, 0);
                else chk("mem_raddr", int'(bus.MEM_RADDR), exp_raddr.pop_front());
            end
            exp_dv = bus.MEM_READ;
        end
    end

    task automatic queue_write();
        exp_waddr.push_back(exp_wptr);
        exp_wptr = (exp_wptr + 1) & PMASK;
    endtask

    task automatic queue_read();
        exp_raddr.push_back(exp_rptr);
        exp_rptr = (exp_rptr + 1) & PMASK;
    endtask

    task automatic push_one();
        bus.PUSH = 1'b1;
        queue_write();
        tick();
        bus.PUSH = 1'b0;
    endtask

    task automatic pop_one();
        bus.POP = 1'b1;
        queue_read();
        tick();
        bus.POP = 1'b0;
    endtask

    initial begin
        RST         = 1'b1;
        bus.CLEAR   = 1'b0;
        bus.FIFO64  = 1'b0;
        bus.TRIG    = 2'b00;
        bus.PUSH    = 1'b0;
        bus.POP     = 1'b0;
        bus.OVR_CLR = 1'b0;
        #12;
        // Reset state
        chk("rst_count",    int'(bus.COUNT), 0);
        chk("rst_empty",    int'(bus.EMPTY), 1);
        chk("rst_full",     int'(bus.FULL), 0);
        chk("rst_trig_hit", int'(bus.TRIG_HIT), 0);
        chk("rst_overrun",  int'(bus.OVERRUN), 0);
        chk("rst_dvalid",   int'(bus.DVALID), 0);
        chk("rst_strobes",  int'({bus.MEM_READ, bus.MEM_WRITE}), 0);
        tick();
        RST = 1'b0;

        // 64-byte mode: first cycle after the switch is a flush.
        bus.FIFO64 = 1'b1;
        tick();
        chk("mode_flush_count", int'(bus.COUNT), 0);
        for (int i = 0; i < 64; i++) begin
            bus.PUSH = 1'b1;
            queue_write();
            tick();
            chk("fill_count", int'(bus.COUNT), i + 1);
        end
        chk("fill_full",  int'(bus.FULL), 1);
        chk("fill_empty", int'(bus.EMPTY), 0);
        chk("push_rdy_when_full", int'(bus.PUSH_RDY), 0);
        tick();
        bus.PUSH = 1'b0;
        chk("overrun_set", int'(bus.OVERRUN), 1);
        chk("count_after_overrun", int'(bus.COUNT), 64);
        bus.OVR_CLR = 1'b1;
        tick();
        bus.OVR_CLR = 1'b0;
        chk("overrun_cleared", int'(bus.OVERRUN), 0);

        // Drain with POP held high.
        bus.POP = 1'b1;
        for (int i = 0; i < 64; i++) begin
            queue_read();
            tick();
        end
        chk("drain_empty", int'(bus.EMPTY), 1);
        chk("drain_count", int'(bus.COUNT), 0);
        chk("pop_empty_no_read", int'(bus.MEM_READ), 0);
        tick();
        chk("pop_empty_no_dvalid", int'(bus.DVALID), 0);
        bus.POP = 1'b0;

        // Simultaneous push and pop with COUNT=5: pops only.
        for (int i = 0; i < 5; i++) push_one();
        chk("count_5", int'(bus.COUNT), 5);
        bus.PUSH = 1'b1;
        bus.POP  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            queue_read();
            #1;
            chk("push_rdy_during_pop", int'(bus.PUSH_RDY), 0);
            tick();
        end
        bus.PUSH = 1'b0;
        bus.POP  = 1'b0;
        chk("count_after_pushpop", int'(bus.COUNT), 2);
        pop_one();
        pop_one();
        chk("count_drained_again", int'(bus.COUNT), 0);

        // Wrap: write pointer runs past 127 back to 0.
        for (int i = 0; i < 100; i++) begin
            push_one();
            chk("wrap_count_hi", int'(bus.COUNT <= 1), 1);
            pop_one();
            chk("wrap_count_lo", int'(bus.COUNT), 0);
        end

        // 16-byte mode, TRIG=2'b10 -> threshold 8.
        bus.FIFO64 = 1'b0;
        bus.TRIG   = 2'b10;
        tick();
        exp_wptr = 0;
        exp_rptr = 0;
        chk("mode16_flush", int'(bus.COUNT), 0);
        chk("mode16_waddr", int'(bus.MEM_WADDR), 0);
        for (int k = 1; k <= 16; k++) begin
            push_one();
            chk("trig_hit16", int'(bus.TRIG_HIT), int'(k >= 8));
            chk("full16",     int'(bus.FULL), int'(k == 16));
        end
        // Overrun set coinciding with OVR_CLR: set wins.
        bus.PUSH    = 1'b1;
        bus.OVR_CLR = 1'b1;
        tick();
        bus.PUSH    = 1'b0;
        bus.OVR_CLR = 1'b0;
        chk("overrun_set_wins", int'(bus.OVERRUN), 1);
        chk("count16_held", int'(bus.COUNT), 16);

        bus.FIFO64 = 1'b1;
        tick();
        exp_wptr = 0;
        exp_rptr = 0;
        chk("mode64_flush_count", int'(bus.COUNT), 0);
        chk("mode64_flush_empty", int'(bus.EMPTY), 1);
        chk("flush_keeps_overrun", int'(bus.OVERRUN), 1);

        // Asynchronous reset mid-burst with COUNT=20, OVERRUN=1.
        bus.PUSH = 1'b1;
        for (int i = 0; i < 20; i++) begin
            queue_write();
            tick();
        end
        chk("burst_count", int'(bus.COUNT), 20);
        chk("burst_overrun", int'(bus.OVERRUN), 1);
        #2;
        RST = 1'b1;
        #1;
        chk("async_count",   int'(bus.COUNT), 0);
        chk("async_empty",   int'(bus.EMPTY), 1);
        chk("async_overrun", int'(bus.OVERRUN), 0);
        chk("async_waddr",   int'(bus.MEM_WADDR), 0);
        chk("async_raddr",   int'(bus.MEM_RADDR), 0);
        chk("async_strobes", int'({bus.MEM_READ, bus.MEM_WRITE}), 0);
        bus.PUSH = 1'b0;
        tick();
        RST = 1'b0;
        tick();

        chk("write_queue_drained", exp_waddr.size(), 0);
        chk("read_queue_drained",  exp_raddr.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/uart_fifo_ctrl.md
Name: uart_fifo_ctrl

Overview:
- Pointer, flag and handshake controller for the UART 16750 RX/TX FIFO storage array.
- Generates read/write strobes and addresses for the 2**SIZE_E-entry registered-read memory.
- Tracks fill level, trigger level, full/empty and overrun.
- Supports 16750 16-byte and 64-byte FIFO modes.

Parameters:
- SIZE_E, 6, log2 of physical memory depth. SIZE_E must be >= 4.
- TRIG16, {4'd14,4'd8,4'd4,4'd1}, trigger thresholds in 16-byte mode, indexed by TRIG.
- TRIG64, {6'd56,6'd32,6'd16,6'd1}, trigger thresholds in 64-byte mode, indexed by TRIG.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  reset, asynchronous, active-high.
- CLEAR  in  1  synchronous flush of pointers, count and DVALID.
- FIFO64  in  1  1 = capacity 2**SIZE_E; 0 = capacity 16.
- TRIG  in  2  trigger level select.
- PUSH  in  1  upstream write request; data is held stable until accepted.
- PUSH_RDY  out  1  write accepted this cycle when PUSH && PUSH_RDY.
- POP  in  1  downstream read request.
- DVALID  out  1  memory Q holds popped data this cycle.
- MEM_READ  out  1  memory read strobe.
- MEM_WRITE  out  1  memory write strobe.
- MEM_RADDR  out  SIZE_E+1  memory read address; MSB is the wrap bit.
- MEM_WADDR  out  SIZE_E+1  memory write address; MSB is the wrap bit.
- COUNT  out  SIZE_E+1  current fill level.
- EMPTY  out  1  COUNT==0.
- FULL  out  1  COUNT==capacity.
- TRIG_HIT  out  1  COUNT >= selected threshold.
- OVERRUN  out  1  sticky: push attempted while full.
- OVR_CLR  in  1  clears OVERRUN.

Behaviour:
- Reset (RST high, asynchronous): all registered state and outputs go to their idle values at once.
  - rptr=0, wptr=0, COUNT=0.
  - DVALID=0, OVERRUN=0, fifo64_q=0.
  - EMPTY=1, FULL=0, TRIG_HIT=0, MEM_READ=0, MEM_WRITE=0.
  - Reset mid-operation discards all contents; nothing is held or replayed.
- Capacity: cap = FIFO64 ? 2**SIZE_E : 16.
- Accept rules (combinational, same cycle):
  - pop_ok = POP && !EMPTY && !CLEAR.
  - PUSH_RDY = !FULL && !pop_ok && !CLEAR.
  - The memory gives READ priority over WRITE, so read and write strobes are never issued together. A simultaneous push and pop executes the pop only; upstream retries the push next cycle.
- Strobes and addresses:
  - MEM_READ = pop_ok; MEM_RADDR = rptr.
  - MEM_WRITE = PUSH && PUSH_RDY; MEM_WADDR = wptr.
- Pointer update (registered):
  - rptr += pop_ok; wptr += MEM_WRITE.
  - Both pointers are SIZE_E+1 bits, free-running, modulo 2**(SIZE_E+1). The memory uses only the low SIZE_E bits, so wrap is implicit.
- COUNT update: +1 on write, -1 on pop; never both in one cycle. COUNT never exceeds cap and never underflows.
- Read latency: DVALID is registered pop_ok, high exactly one cycle after MEM_READ, aligned with memory Q.
- POP when EMPTY: ignored. No strobe, DVALID=0 next cycle, no error.
- PUSH when FULL:
  - PUSH_RDY=0 and no write.
  - OVERRUN is set on the next edge.
  - OVERRUN stays set until OVR_CLR or RST. If OVR_CLR and a new overrun coincide, set wins.
- TRIG_HIT: COUNT >= (FIFO64 ? TRIG64[TRIG] : TRIG16[TRIG]). Combinational from registered COUNT.
- CLEAR:
  - Next edge: rptr=wptr=0, COUNT=0, DVALID=0.
  - Suppresses all strobes in the CLEAR cycle.
  - OVERRUN is unaffected.
- Mode change: fifo64_q registers FIFO64. Any cycle with FIFO64 != fifo64_q acts as CLEAR, giving an automatic flush on mode switch.
- Flags are decoded from registered state only. No combinational path from PUSH or POP to EMPTY, FULL or TRIG_HIT.

Test Plan:
- Reset, then 64-byte mode: 64 pushes of 0x00..0x3F.
  - Required: COUNT steps 1..64, FULL=1 after the 64th push, EMPTY=0.
  - MEM_WADDR runs 0..63. The 65th push sees PUSH_RDY=0 and sets OVERRUN.
- Drain the full FIFO with POP held high.
  - Required: MEM_RADDR 0..63, DVALID one cycle after each MEM_READ.
  - After 64 pops EMPTY=1; a further POP produces no MEM_READ.
- With COUNT=5, hold PUSH and POP together for 3 cycles.
  - Required: 3 pops, 0 writes, PUSH_RDY=0 throughout, COUNT=2.
  - MEM_READ and MEM_WRITE never high together.
- Wrap test: 100 push/pop pairs in alternating cycles.
  - Required: MEM_WADDR passes 127 then 0, low bits wrap at 64, COUNT stays within 0..1.
- 16-byte mode with TRIG=2'b10.
  - Required: TRIG_HIT rises when COUNT reaches 8; FULL at 16.
  - Toggling FIFO64 to 1 flushes: COUNT=0 next cycle.
- Assert RST asynchronously mid-burst with COUNT=20 and OVERRUN=1.
  - Required: all flags and pointers return to reset values immediately, without waiting for a clock edge.
